// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and WIDTH bounds.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder_bit.sv
// Combinational 1-bit full-adder cell shared by every bit position of the serial datapath.
module full_adder_bit
    import serial_addsub_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = maj3(a_i, b_i, c_i);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor with start/busy/done handshake, LSB-first.
// SERIAL_ADDSUB_SUB_EN enables subtraction through the sub_i input; without it the block only adds.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             s_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] opb_load;
    logic             carry_load;
    logic             accept;

    full_adder_bit u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (bit_d),
        .c_o (carry_d)
    );

`ifdef SERIAL_ADDSUB_SUB_EN
    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
    assign opb_load   = sub_i ? ~b_i : b_i;
    assign carry_load = sub_i;
`else
    logic unused_sub;
    assign unused_sub = sub_i;
    assign opb_load   = b_i;
    assign carry_load = 1'b0;
`endif

    assign accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en_i) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        opa_q   <= a_i;
                        opb_q   <= opb_load;
                        carry_q <= carry_load;
                        cnt_q   <= CNT_LAST;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    sum_q   <= {bit_d, sum_q[WIDTH-1:1]};
                    s_q     <= bit_d;
                    carry_q <= carry_d;
                    if (cnt_q == '0) begin
                        // carry_q here is the carry into the MSB, carry_d the carry out of it.
                        cout_q  <= carry_d;
                        ovf_q   <= carry_q ^ carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_o    = s_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8) against an arithmetic reference model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         start = 1'b0;
    logic         sub_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         s;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .start_i (start),
        .sub_i   (sub_in),
        .a_i     (a_in),
        .b_i     (b_in),
        .s_o     (s),
        .sum_o   (sum),
        .cout_o  (cout),
        .ovf_o   (ovf),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, carry/borrow and signed range test.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                         output logic [W-1:0] r, output logic c, output logic o);
        logic eff;
        int   ua, ub, sa, sbv, sres;
`ifdef SERIAL_ADDSUB_SUB_EN
        eff = sb;
`else
        eff = 1'b0;
`endif
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= 128) ? ua - 256 : ua;
        sbv = (ub >= 128) ? ub - 256 : ub;
        if (eff) begin
            r    = W'(ua - ub);
            c    = (ua >= ub);
            sres = sa - sbv;
        end else begin
            r    = W'(ua + ub);
            c    = ((ua + ub) > 255);
            sres = sa + sbv;
        end
        o = (sres > 127) || (sres < -128);
    endtask

    // Starts an operation and follows it to the done cycle; returns in that cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                          input int poke);
        logic [W-1:0] er;
        logic         ec, eo;
        model(a, b, sb, er, ec, eo);
        a_in = a; b_in = b; sub_in = sb; start = 1'b1;
        tick();
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); sub_in = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            check("busy", busy, 1);
            check("done_early", done, 0);
            if (i == poke) start = 1'b1;
            tick();
            start = 1'b0;
            check("s_bit", s, er[i]);
        end
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("sum", sum, er);
        check("cout", cout, ec);
        check("ovf", ovf, eo);
    endtask

    initial begin
        logic [W-1:0] er, s_hold;
        logic         ec, eo;
        int           edges;

        tick(); tick();
        check("rst_sum", sum, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        run_op(8'h5A, 8'h3C, 1'b0, -1);
        tick();
        check("done_clear", done, 0);
        check("sum_held", sum, 8'h96);
        run_op(8'hFF, 8'h01, 1'b0, -1);
        run_op(8'h10, 8'h20, 1'b1, -1);      // back-to-back from DONE
        run_op(8'h80, 8'h01, 1'b1, 3);       // start pulse mid-shift is ignored
        tick();

        // Clock-enable freeze for 3 cycles mid-operation.
        model(8'h12, 8'h34, 1'b0, er, ec, eo);
        a_in = 8'h12; b_in = 8'h34; sub_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            en = (edges >= 3 && edges < 6) ? 1'b0 : 1'b1;
            s_hold = {7'd0, s};
            tick();
            edges++;
            if (!en) begin
                check("frozen_s", s, s_hold[0]);
                check("frozen_busy", busy, 1);
            end
        end
        en = 1'b1;
        check("en_latency", edges, W + 3);
        check("en_sum", sum, er);
        check("en_cout", cout, ec);
        en = 1'b0;
        tick(); tick();
        check("done_hold_en_low", done, 1);
        en = 1'b1;
        tick();
        check("done_after_en", done, 0);

        // Reset at bit 4 with a simultaneous start: reset wins.
        a_in = 8'hA5; b_in = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("abort_sum", sum, 0);
        check("abort_s", s, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end
        run_op(8'h21, 8'h43, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 15)) - 4);
            if ($urandom_range(0, 2) == 0) begin
                tick();
                check("idle_done", done, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
